// File: rtl/gated_edge_counter.sv
// Counts rising edges of an asynchronous input over a fixed window of clk cycles.
// The result is published on count_out together with a one-cycle count_valid strobe.
//
// state  | meaning
// S_IDLE | waiting for start or continuous
// S_GATE | gate window open, edges counted
// S_DONE | result cycle (count_valid high), then re-arm or idle
module gated_edge_counter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_q;
  logic [GATE_W-1:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       count_out_q, count_out_d;
  logic                   overflow_q, overflow_d;
  logic                   sig_s;
  logic                   edge_p;

  assign sig_s  = sync_q[SYNC_STAGES-1];
  assign edge_p = sig_s & ~sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      sig_q       <= 1'b0;
      state_q     <= S_IDLE;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      count_out_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_q       <= sig_s;
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      count_out_q <= count_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    count_out_d = count_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          state_d    = S_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      S_GATE: begin
        // Saturate rather than wrap; an edge arriving at full scale marks overflow.
        if (edge_p) begin
          if (edge_cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d     = S_DONE;
          count_out_d = edge_cnt_d;
          overflow_d  = ovf_d;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
        end
      end
      S_DONE: begin
        if (continuous) begin
          state_d    = S_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign count_valid = (state_q == S_DONE);
  assign count_out   = count_out_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_gated_edge_counter.sv
// Self-checking bench for gated_edge_counter (100-cycle window, 4-bit counter).
module tb_gated_edge_counter;
  localparam int GC = 100;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          busy, count_valid, overflow;
  logic [CW-1:0] count_out;

  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  int   sig_period = 4;
  logic sig_level = 1'b0;
  int   ph = 0;

  typedef struct packed {logic [CW-1:0] cnt; logic ovf;} exp_t;
  exp_t sb_q[$];

  gated_edge_counter #(.GATE_CYCLES(GC), .CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy), .count_out(count_out), .count_valid(count_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Stimulus signal changes 3 time units after the rising clock edge, unrelated to sampling.
  initial forever begin
    @(posedge clk);
    #3;
    if (sig_period == 0) sig_in = sig_level;
    else begin
      if (ph >= sig_period) ph = 0;
      sig_in = (ph < sig_period / 2);
      ph++;
    end
  end

  always @(posedge clk) if (count_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  function automatic exp_t model(int edges);
    exp_t e;
    e.ovf = (edges > (2 ** CW - 1));
    e.cnt = e.ovf ? {CW{1'b1}} : edges[CW-1:0];
    return e;
  endfunction

  task automatic settle(int period, logic lvl, int n);
    sig_period = period;
    sig_level  = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (count_valid !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sig_period = 4;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (count_out !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_out); end
    checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", count_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    repeat (200) @(negedge clk);
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL idle_no_valid got=%0d exp=0", valid_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int   c;
    exp_t e;
    settle(10, 1'b0, 20);
    sb_q.push_back(model(GC / 10));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
    wait_valid(c);
    checks++; if (c !== GC + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", c, GC + 1); end
    if (count_valid === 1'b1) begin
      e = sb_q.pop_front();
      checks++; if (count_out !== e.cnt) begin errors++; $display("FAIL single_count got=%0d exp=%0d", count_out, e.cnt); end
      checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL single_ovf got=%b exp=%b", overflow, e.ovf); end
    end else begin
      checks++; errors++; $display("FAIL single_timeout got=no_valid exp=valid");
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    checks++; if (count_valid !== 1'b0) begin errors++; $display("FAIL single_valid_len got=%b exp=0", count_valid); end
  endtask

  task automatic test_saturate();
    int   c;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      settle((k == 0) ? 4 : 10, 1'b0, 20);
      sb_q.push_back(model((k == 0) ? GC / 4 : GC / 10));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(c);
      if (count_valid === 1'b1) begin
        e = sb_q.pop_front();
        checks++; if (count_out !== e.cnt) begin errors++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, count_out, e.cnt); end
        checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL sat_ovf[%0d] got=%b exp=%b", k, overflow, e.ovf); end
      end else begin
        checks++; errors++; $display("FAIL sat_timeout[%0d] got=no_valid exp=valid", k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_continuous();
    int   prev = 0;
    int   nv = 0;
    exp_t e;
    settle(10, 1'b0, 20);
    sb_q.push_back(model(GC / 10));
    continuous = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 350) continuous = 1'b0;
      if (count_valid === 1'b1) begin
        nv++;
        if (sb_q.size() == 0) begin
          checks++; errors++; $display("FAIL cont_unexpected got=valid@%0d exp=none", c);
        end else begin
          e = sb_q.pop_front();
          checks++; if (count_out !== e.cnt) begin errors++; $display("FAIL cont_count got=%0d exp=%0d", count_out, e.cnt); end
        end
        if (prev != 0) begin
          checks++; if (c - prev !== GC + 1) begin errors++; $display("FAIL cont_spacing got=%0d exp=%0d", c - prev, GC + 1); end
        end
        prev = c;
        if (continuous) sb_q.push_back(model(GC / 10));
      end
    end
    checks++; if (nv !== 4) begin errors++; $display("FAIL cont_windows got=%0d exp=4", nv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got=%b exp=0", busy); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL cont_pending got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_ignore_abort();
    int   lat = 0;
    int   snap;
    int   c;
    exp_t e;
    settle(10, 1'b0, 20);
    sb_q.push_back(model(GC / 10));
    snap  = valid_cnt;
    start = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      start = (i == 50);
      if (count_valid === 1'b1 && lat == 0) lat = i;
    end
    checks++; if (lat !== GC + 1) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, GC + 1); end
    checks++; if (valid_cnt - snap !== 1) begin errors++; $display("FAIL ignore_one_valid got=%0d exp=1", valid_cnt - snap); end
    e = sb_q.pop_front();
    checks++; if (count_out !== e.cnt) begin errors++; $display("FAIL ignore_count got=%0d exp=%0d", count_out, e.cnt); end

    sb_q.push_back(model(GC / 10));
    start = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete(sb_q.size() - 1);
    checks++; if (count_out !== '0) begin errors++; $display("FAIL abort_count got=%0d exp=0", count_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    snap = valid_cnt;
    repeat (200) @(negedge clk);
    checks++; if (valid_cnt !== snap) begin errors++; $display("FAIL abort_no_valid got=%0d exp=%0d", valid_cnt, snap); end

    sb_q.push_back(model(GC / 10));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(c);
    checks++; if (c !== GC + 1) begin errors++; $display("FAIL restart_latency got=%0d exp=%0d", c, GC + 1); end
    e = sb_q.pop_front();
    checks++; if (count_out !== e.cnt) begin errors++; $display("FAIL restart_count got=%0d exp=%0d", count_out, e.cnt); end
    @(negedge clk);
  endtask

  task automatic test_constant();
    int   c;
    int   lat = 0;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      settle(0, (k == 0), 20);
      sb_q.push_back(model(0));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_valid(c);
      e = sb_q.pop_front();
      checks++; if (count_valid !== 1'b1 || count_out !== e.cnt) begin errors++; $display("FAIL const_count[%0d] got=%0d/%b exp=%0d/1", k, count_out, count_valid, e.cnt); end
      checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL const_ovf[%0d] got=%b exp=%b", k, overflow, e.ovf); end
      @(negedge clk);
    end
    settle(0, 1'b0, 20);
    sb_q.push_back(model(1));
    start = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      start     = 1'b0;
      sig_level = (i == 50);
      if (count_valid === 1'b1 && lat == 0) begin
        lat = i;
        e   = sb_q.pop_front();
        checks++; if (count_out !== e.cnt) begin errors++; $display("FAIL pulse_count got=%0d exp=%0d", count_out, e.cnt); end
      end
    end
    checks++; if (lat !== GC + 1) begin errors++; $display("FAIL pulse_latency got=%0d exp=%0d", lat, GC + 1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_continuous();
    test_ignore_abort();
    test_constant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
